conv_window_memory: RTL and testbench

Sliding-window pixel buffer feeding the Gaussian convolution stage. It fetches pixels from the single-port image SRAM and keeps a kernel_size × kernel_size window anchored at the current traversal position. On each move of the serpentine traversal it refetches only the newly exposed column or row. It sits between the image SRAM, the pixel-position tracker (which supplies curr_x, curr_y and next_dir) and the convolution datapath.

---
 rtl/conv_window_memory_pkg.sv | 39 +++
 rtl/conv_window_memory_fetch_seq.sv | 125 ++++++++++++
 rtl/conv_window_memory.sv | 213 +++++++++++++++++++++
 tb/tb_conv_window_memory.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_memory_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared types for the sliding-window pixel buffer:
//   dir_t         - traversal direction of the next move (2'b11 acts as down)
//   state_t       - window FSM states
//   clamp_kernel  - limits a requested kernel edge to 1..kmax
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10
    } dir_t;

    // LOAD and SHIFT are the one-cycle gaps in which the tracker position
    // settles before the fetch sequencer is started.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_FULL_FILL = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_EDGE_FILL = 3'd4,
        ST_READY     = 3'd5
    } state_t;

    function automatic logic [7:0] clamp_kernel(input logic [7:0] ks, input logic [7:0] kmax);
        logic [7:0] k;
        if (ks == 8'd0) begin
            k = 8'd1;
        end else if (ks > kmax) begin
            k = kmax;
        end else begin
            k = ks;
        end
        return k;
    endfunction

endpackage

// File: rtl/conv_window_memory_fetch_seq.sv
// ---------------------------------------------------------------------------
// conv_fetch_seq
// Walks a rectangle of nrows x ncols pixels in row-major order, issuing one
// SRAM read per cycle, and reports the matching window write index one cycle
// later (when the SRAM data is valid).
// Ports:
//   clk, n_rst            - clock, synchronous active-high reset
//   i_abort               - drop any walk in flight and any pending write
//   i_start               - begin a walk with the i_* geometry below
//   i_base_x/i_base_y     - image address of the rectangle's top-left pixel
//   i_nrows/i_ncols       - rectangle size
//   i_row0/i_col0         - window index of the rectangle's top-left entry
//   o_ren, o_x, o_y       - SRAM read strobe and address
//   o_wr_en, o_wr_last    - write strobe for returned data, last write flag
//   o_wr_row, o_wr_col    - window index for the returned data
// ---------------------------------------------------------------------------
module conv_fetch_seq #(
    parameter int XW = 4,
    parameter int YW = 4,
    parameter int KW = 2
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_abort,
    input  logic          i_start,
    input  logic [XW-1:0] i_base_x,
    input  logic [YW-1:0] i_base_y,
    input  logic [KW-1:0] i_nrows,
    input  logic [KW-1:0] i_ncols,
    input  logic [KW-1:0] i_row0,
    input  logic [KW-1:0] i_col0,
    output logic          o_ren,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_wr_en,
    output logic          o_wr_last,
    output logic [KW-1:0] o_wr_row,
    output logic [KW-1:0] o_wr_col
);

    logic          r_ren;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] r_bx;
    logic [KW-1:0] r_row;
    logic [KW-1:0] r_col;
    logic [KW-1:0] r_nrows;
    logic [KW-1:0] r_ncols;
    logic [KW-1:0] r_row0;
    logic [KW-1:0] r_col0;
    logic          r_wr_en;
    logic          r_wr_last;
    logic [KW-1:0] r_wr_row;
    logic [KW-1:0] r_wr_col;
    logic          w_last;

    // The read being issued this cycle is the final one of the rectangle.
    always_comb begin
        w_last = (r_row == (r_nrows - KW'(1))) && (r_col == (r_ncols - KW'(1)));
    end

    // Read address walk plus the one-cycle-delayed write index.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_ren     <= 1'b0;
            r_x       <= {XW{1'b0}};
            r_y       <= {YW{1'b0}};
            r_bx      <= {XW{1'b0}};
            r_row     <= {KW{1'b0}};
            r_col     <= {KW{1'b0}};
            r_nrows   <= {KW{1'b0}};
            r_ncols   <= {KW{1'b0}};
            r_row0    <= {KW{1'b0}};
            r_col0    <= {KW{1'b0}};
            r_wr_en   <= 1'b0;
            r_wr_last <= 1'b0;
            r_wr_row  <= {KW{1'b0}};
            r_wr_col  <= {KW{1'b0}};
        end else if (i_abort) begin
            r_ren     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_last <= 1'b0;
        end else begin
            r_wr_en   <= r_ren;
            r_wr_last <= r_ren & w_last;
            r_wr_row  <= r_row0 + r_row;
            r_wr_col  <= r_col0 + r_col;
            if (i_start) begin
                r_ren   <= 1'b1;
                r_x     <= i_base_x;
                r_y     <= i_base_y;
                r_bx    <= i_base_x;
                r_row   <= {KW{1'b0}};
                r_col   <= {KW{1'b0}};
                r_nrows <= i_nrows;
                r_ncols <= i_ncols;
                r_row0  <= i_row0;
                r_col0  <= i_col0;
            end else if (r_ren) begin
                if (w_last) begin
                    r_ren <= 1'b0;
                end else if (r_col == (r_ncols - KW'(1))) begin
                    r_col <= {KW{1'b0}};
                    r_row <= r_row + KW'(1);
                    r_x   <= r_bx;
                    r_y   <= r_y + YW'(1);
                end else begin
                    r_col <= r_col + KW'(1);
                    r_x   <= r_x + XW'(1);
                end
            end else begin
                r_ren <= 1'b0;
            end
        end
    end

    assign o_ren     = r_ren;
    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_wr_en   = r_wr_en;
    assign o_wr_last = r_wr_last;
    assign o_wr_row  = r_wr_row;
    assign o_wr_col  = r_wr_col;

endmodule

// File: rtl/conv_window_memory.sv
// ---------------------------------------------------------------------------
// conv_window_memory
// Sliding k x k pixel window for the Gaussian convolution stage. A new image
// loads the whole window; each serpentine move shifts the window and refetches
// only the newly exposed column or row from the single-port image SRAM.
// Ports:
//   clk, n_rst                  - clock, synchronous active-high reset
//   x_addr_img, y_addr_img      - SRAM read address
//   ren_img, rdat_img           - SRAM read strobe, data (valid one cycle later)
//   kernel_size                 - requested window edge (clamped to 1..MAX_KERNAL)
//   next_dir, curr_x, curr_y    - tracker direction and window anchor
//   new_trans, new_sample_req   - start new image / consume window and move
//   new_sample_ready            - window valid for current anchor
//   working_memory              - window, [row][col]; entries beyond k read 0
// ---------------------------------------------------------------------------
module conv_window_memory
    import conv_pkg::*;
#(
    parameter int MAX_KERNAL  = 3,
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16,
    parameter int PIXEL_DEPTH = 8,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX),
    localparam int KW = $clog2(MAX_KERNAL + 1)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    output logic [XW-1:0]          x_addr_img,
    output logic [YW-1:0]          y_addr_img,
    output logic                   ren_img,
    input  logic [PIXEL_DEPTH-1:0] rdat_img,
    input  logic [7:0]             kernel_size,
    input  logic [1:0]             next_dir,
    input  logic [XW-1:0]          curr_x,
    input  logic [YW-1:0]          curr_y,
    input  logic                   new_trans,
    input  logic                   new_sample_req,
    output logic                   new_sample_ready,
    output logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][PIXEL_DEPTH-1:0] working_memory
);

    state_t        r_state;
    logic          r_ready;
    logic [KW-1:0] r_k;
    logic [1:0]    r_dir;
    logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][PIXEL_DEPTH-1:0] r_win;
    logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][PIXEL_DEPTH-1:0] w_shifted;

    logic [KW-1:0] w_k_eff;
    logic          w_start;
    logic [XW-1:0] w_base_x;
    logic [YW-1:0] w_base_y;
    logic [KW-1:0] w_nrows;
    logic [KW-1:0] w_ncols;
    logic [KW-1:0] w_row0;
    logic [KW-1:0] w_col0;
    logic          w_wr_en;
    logic          w_wr_last;
    logic [KW-1:0] w_wr_row;
    logic [KW-1:0] w_wr_col;

    // Fetch geometry: whole window after LOAD, one column/row after SHIFT.
    always_comb begin
        w_k_eff  = KW'(clamp_kernel(kernel_size, 8'(MAX_KERNAL)));
        w_start  = 1'b0;
        w_base_x = curr_x;
        w_base_y = curr_y;
        w_nrows  = r_k;
        w_ncols  = r_k;
        w_row0   = {KW{1'b0}};
        w_col0   = {KW{1'b0}};
        case (r_state)
            ST_LOAD: begin
                w_start = ~new_trans;
                w_nrows = w_k_eff;
                w_ncols = w_k_eff;
            end
            ST_SHIFT: begin
                w_start = ~new_trans;
                case (r_dir)
                    DIR_RIGHT: begin
                        w_ncols  = KW'(1);
                        w_col0   = r_k - KW'(1);
                        w_base_x = curr_x + XW'(r_k - KW'(1));
                    end
                    DIR_LEFT: begin
                        w_ncols = KW'(1);
                    end
                    default: begin
                        w_nrows  = KW'(1);
                        w_row0   = r_k - KW'(1);
                        w_base_y = curr_y + YW'(r_k - KW'(1));
                    end
                endcase
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Window after a move; only entries inside the active k x k area move,
    // so unused entries stay zero. The exposed edge keeps stale data until
    // the refill overwrites it.
    always_comb begin
        w_shifted = r_win;
        for (int i = 0; i < MAX_KERNAL; i++) begin
            for (int j = 0; j < MAX_KERNAL; j++) begin
                case (next_dir)
                    DIR_RIGHT: begin
                        if (j < int'(r_k) - 1) begin
                            w_shifted[i][j] = r_win[i][(j + 1 < MAX_KERNAL) ? j + 1 : j];
                        end else begin
                            w_shifted[i][j] = r_win[i][j];
                        end
                    end
                    DIR_LEFT: begin
                        if (j > 0 && j < int'(r_k)) begin
                            w_shifted[i][j] = r_win[i][(j > 0) ? j - 1 : j];
                        end else begin
                            w_shifted[i][j] = r_win[i][j];
                        end
                    end
                    default: begin
                        if (i < int'(r_k) - 1) begin
                            w_shifted[i][j] = r_win[(i + 1 < MAX_KERNAL) ? i + 1 : i][j];
                        end else begin
                            w_shifted[i][j] = r_win[i][j];
                        end
                    end
                endcase
            end
        end
    end

    // Window FSM: load, ready handshake, shift and data capture.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_k     <= KW'(1);
            r_dir   <= DIR_RIGHT;
            r_win   <= '0;
        end else if (new_trans) begin
            r_state <= ST_LOAD;
            r_ready <= 1'b0;
            r_win   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_LOAD: begin
                    r_k     <= w_k_eff;
                    r_state <= ST_FULL_FILL;
                end
                ST_FULL_FILL, ST_EDGE_FILL: begin
                    if (w_wr_en) begin
                        r_win[w_wr_row][w_wr_col] <= rdat_img;
                    end
                    if (w_wr_last) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (new_sample_req) begin
                        r_dir   <= next_dir;
                        r_ready <= 1'b0;
                        r_win   <= w_shifted;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_state <= ST_EDGE_FILL;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    conv_fetch_seq #(
        .XW(XW),
        .YW(YW),
        .KW(KW)
    ) u_fetch (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_abort  (new_trans),
        .i_start  (w_start),
        .i_base_x (w_base_x),
        .i_base_y (w_base_y),
        .i_nrows  (w_nrows),
        .i_ncols  (w_ncols),
        .i_row0   (w_row0),
        .i_col0   (w_col0),
        .o_ren    (ren_img),
        .o_x      (x_addr_img),
        .o_y      (y_addr_img),
        .o_wr_en  (w_wr_en),
        .o_wr_last(w_wr_last),
        .o_wr_row (w_wr_row),
        .o_wr_col (w_wr_col)
    );

    assign new_sample_ready = r_ready;
    assign working_memory   = r_win;

endmodule

// File: tb/tb_conv_window_memory.sv
// ---------------------------------------------------------------------------
// tb_conv_window_memory
// Bench for conv_window_memory on a 16x16 image with pixel(x, y) = 16y + x.
// The expected window, read addresses and latencies come from the window
// rules directly (pixel arithmetic on the anchor), not from the RTL structure.
// ---------------------------------------------------------------------------
module tb_conv_window_memory;

    localparam int MK = 3;

    logic                          clk;
    logic                          n_rst;
    logic [3:0]                    x_addr_img;
    logic [3:0]                    y_addr_img;
    logic                          ren_img;
    logic [7:0]                    rdat_img;
    logic [7:0]                    kernel_size;
    logic [1:0]                    next_dir;
    logic [3:0]                    curr_x;
    logic [3:0]                    curr_y;
    logic                          new_trans;
    logic                          new_sample_req;
    logic                          new_sample_ready;
    logic [MK-1:0][MK-1:0][7:0]    working_memory;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_q[$];
    int mdl_k, mdl_x, mdl_y;

    conv_window_memory #(
        .MAX_KERNAL (MK),
        .X_MAX      (16),
        .Y_MAX      (16),
        .PIXEL_DEPTH(8)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .x_addr_img      (x_addr_img),
        .y_addr_img      (y_addr_img),
        .ren_img         (ren_img),
        .rdat_img        (rdat_img),
        .kernel_size     (kernel_size),
        .next_dir        (next_dir),
        .curr_x          (curr_x),
        .curr_y          (curr_y),
        .new_trans       (new_trans),
        .new_sample_req  (new_sample_req),
        .new_sample_ready(new_sample_ready),
        .working_memory  (working_memory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image SRAM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (ren_img) rdat_img <= 8'((16 * int'(y_addr_img) + int'(x_addr_img)) & 255);
    end

    // Read monitor: records every issued read address as x + 16*y.
    always @(posedge clk) begin
        if (ren_img) rd_q.push_back(int'(x_addr_img) + 16 * int'(y_addr_img));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampk(input int ks);
        if (ks < 1) return 1;
        if (ks > MK) return MK;
        return ks;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_win(input string tag);
        int bad = 0;
        int e;
        n_tests++;
        for (int i = 0; i < MK; i++) begin
            for (int j = 0; j < MK; j++) begin
                e = (i < mdl_k && j < mdl_k) ? ((16 * (mdl_y + i) + mdl_x + j) & 255) : 0;
                if (int'(working_memory[i][j]) != e) begin
                    if (bad == 0)
                        $display("FAIL %s window[%0d][%0d]: got %0d, expected %0d",
                                 tag, i, j, working_memory[i][j], e);
                    bad++;
                end
            end
        end
        if (bad != 0) n_fail++;
    endtask

    task automatic chk_addr(input string tag, input int exp_q[$]);
        int bad = 0;
        n_tests++;
        if (rd_q.size() != exp_q.size()) begin
            $display("FAIL %s read count: got %0d, expected %0d", tag, rd_q.size(), exp_q.size());
            bad = 1;
        end else begin
            for (int n = 0; n < exp_q.size(); n++) begin
                if (bad == 0 && rd_q[n] != exp_q[n]) begin
                    $display("FAIL %s read %0d addr: got (%0d,%0d), expected (%0d,%0d)", tag, n,
                             rd_q[n] % 16, rd_q[n] / 16, exp_q[n] % 16, exp_q[n] / 16);
                    bad = 1;
                end
            end
        end
        if (bad != 0) n_fail++;
    endtask

    // Counts edges until ready is seen; -1 when the budget expires.
    task automatic wait_ready(input int req_at, output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            new_sample_req = (c - 1 == req_at);
            tick();
            if (new_sample_ready) begin
                lat = c;
                break;
            end
        end
        new_sample_req = 1'b0;
    endtask

    task automatic full_load(input int ks, input int cx, input int cy, input bit with_req,
                             input int req_at, input string tag, output int lat, output int nrd);
        int exp_q[$];
        mdl_k = clampk(ks);
        mdl_x = cx;
        mdl_y = cy;
        kernel_size = 8'(ks);
        curr_x = 4'(cx);
        curr_y = 4'(cy);
        next_dir = 2'b00;
        rd_q.delete();
        new_trans = 1'b1;
        new_sample_req = with_req;
        tick();
        new_trans = 1'b0;
        new_sample_req = 1'b0;
        chk({tag, " ready drop"}, int'(new_sample_ready), 0);
        wait_ready(req_at, lat);
        nrd = rd_q.size();
        for (int r = 0; r < mdl_k; r++)
            for (int c = 0; c < mdl_k; c++)
                exp_q.push_back((cx + c) + 16 * (cy + r));
        chk_addr(tag, exp_q);
        chk_win(tag);
    endtask

    task automatic move(input int dir, input string tag);
        int exp_q[$];
        int lat;
        int nx = mdl_x;
        int ny = mdl_y;
        if (dir == 0) nx = mdl_x + 1;
        else if (dir == 1) nx = mdl_x - 1;
        else ny = mdl_y + 1;
        next_dir = 2'(dir);
        rd_q.delete();
        new_sample_req = 1'b1;
        tick();
        new_sample_req = 1'b0;
        curr_x = 4'(nx);
        curr_y = 4'(ny);
        mdl_x = nx;
        mdl_y = ny;
        chk({tag, " ready drop"}, int'(new_sample_ready), 0);
        wait_ready(-1, lat);
        chk({tag, " latency"}, lat, mdl_k + 2);
        for (int n = 0; n < mdl_k; n++) begin
            if (dir == 0) exp_q.push_back((nx + mdl_k - 1) + 16 * (ny + n));
            else if (dir == 1) exp_q.push_back(nx + 16 * (ny + n));
            else exp_q.push_back((nx + n) + 16 * (ny + mdl_k - 1));
        end
        chk_addr(tag, exp_q);
        chk_win(tag);
    endtask

    task automatic serpentine(input int ks, input string tag);
        int k = clampk(ks);
        int npos = 6 - k + 1;
        int sx = int'($urandom_range(0, 10));
        int sy = int'($urandom_range(0, 10));
        int lat, nrd;
        full_load(ks, sx, sy, 1'b0, -1, {tag, " load"}, lat, nrd);
        chk({tag, " load latency"}, lat, k * k + 2);
        for (int r = 0; r < npos; r++) begin
            for (int m = 0; m < npos - 1; m++)
                move((r % 2 == 0) ? 0 : 1, $sformatf("%s r%0d m%0d", tag, r, m));
            if (r < npos - 1)
                move((r % 2 == 0) ? 2 : 3, $sformatf("%s down%0d", tag, r));
        end
    endtask

    typedef struct {
        int ks;
        int cx;
        int cy;
        int exp_reads;
        int exp_lat;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int lat, nrd, ks, k, cx, cy;

        tbl[0] = '{ks: 3, cx: 0,  cy: 0, exp_reads: 9, exp_lat: 11};
        tbl[1] = '{ks: 1, cx: 5,  cy: 7, exp_reads: 1, exp_lat: 3};
        tbl[2] = '{ks: 8, cx: 2,  cy: 3, exp_reads: 9, exp_lat: 11};
        tbl[3] = '{ks: 2, cx: 10, cy: 4, exp_reads: 4, exp_lat: 6};
        tbl[4] = '{ks: 0, cx: 4,  cy: 4, exp_reads: 1, exp_lat: 3};

        n_rst = 1'b1;
        kernel_size = 8'd3;
        next_dir = 2'b00;
        curr_x = 4'd0;
        curr_y = 4'd0;
        new_trans = 1'b0;
        new_sample_req = 1'b0;
        tick();
        tick();
        mdl_k = 0;
        mdl_x = 0;
        mdl_y = 0;
        chk("reset ren", int'(ren_img), 0);
        chk("reset x_addr", int'(x_addr_img), 0);
        chk("reset y_addr", int'(y_addr_img), 0);
        chk("reset ready", int'(new_sample_ready), 0);
        chk_win("reset");
        n_rst = 1'b0;
        tick();

        // Full loads from the vector table.
        for (int t = 0; t < 5; t++) begin
            full_load(tbl[t].ks, tbl[t].cx, tbl[t].cy, 1'b0, -1, $sformatf("vec%0d", t), lat, nrd);
            chk($sformatf("vec%0d latency", t), lat, tbl[t].exp_lat);
            chk($sformatf("vec%0d reads", t), nrd, tbl[t].exp_reads);
        end

        // Load at origin then one move right.
        full_load(3, 0, 0, 1'b0, -1, "origin", lat, nrd);
        chk("origin latency", lat, 11);
        move(0, "origin right");

        serpentine(3, "serp3");
        serpentine(int'($urandom_range(1, 3)), "serpR");

        // Random full loads.
        for (int t = 0; t < 6; t++) begin
            ks = int'($urandom_range(0, 9));
            k = clampk(ks);
            cx = int'($urandom_range(0, 16 - k));
            cy = int'($urandom_range(0, 16 - k));
            full_load(ks, cx, cy, 1'b0, -1, $sformatf("rnd%0d", t), lat, nrd);
            chk($sformatf("rnd%0d latency", t), lat, k * k + 2);
            chk($sformatf("rnd%0d reads", t), nrd, k * k);
        end

        // Request during a fill is ignored.
        full_load(3, 4, 5, 1'b0, 3, "req in fill", lat, nrd);
        chk("req in fill latency", lat, 11);
        chk("req in fill reads", nrd, 9);

        // Request together with new_trans from READY: full reload wins.
        full_load(3, 2, 2, 1'b1, -1, "req+trans", lat, nrd);
        chk("req+trans latency", lat, 11);
        chk("req+trans reads", nrd, 9);

        // Request while not ready (IDLE after reset): no reads.
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        rd_q.delete();
        new_sample_req = 1'b1;
        tick();
        new_sample_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("idle req reads", rd_q.size(), 0);
        chk("idle req ready", int'(new_sample_ready), 0);

        // Reset in the middle of a full fill.
        kernel_size = 8'd3;
        curr_x = 4'd6;
        curr_y = 4'd6;
        new_trans = 1'b1;
        tick();
        new_trans = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("mid-fill ren before reset", int'(ren_img), 1);
        n_rst = 1'b1;
        tick();
        mdl_k = 0;
        chk("mid-fill reset ren", int'(ren_img), 0);
        chk("mid-fill reset x_addr", int'(x_addr_img), 0);
        chk("mid-fill reset y_addr", int'(y_addr_img), 0);
        chk("mid-fill reset ready", int'(new_sample_ready), 0);
        chk_win("mid-fill reset");
        n_rst = 1'b0;
        rd_q.delete();
        for (int c = 0; c < 10; c++) tick();
        chk("post-reset reads", rd_q.size(), 0);
        chk("post-reset ready", int'(new_sample_ready), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
